// File: rtl/axis_merge_2x_pkg.sv
// Shared constants for the two-input AXI-stream merger: source tags and the
// elaboration-time legality check on the per-input FIFO depth.
package axis_merge_2x_pkg;

  localparam logic SRC_I1 = 1'b0;
  localparam logic SRC_I2 = 1'b1;

  function automatic bit depth_legal(int unsigned depth);
    return (depth >= 2) && (depth <= 64) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_nr.sv
// Single-clock FIFO with a combinational head read and no bypass: a push into an
// empty FIFO is only visible at the head after the write edge.
module sync_fifo_nr #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [AW:0]      level_o,
  output logic             accept_o
);

  localparam logic [AW:0]   LvlFull = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LvlOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             pop_ok;

  // A full FIFO still accepts when the head leaves on the same edge.
  assign pop_ok   = pop_i && (level_q != '0);
  assign accept_o = push_i && ((level_q != LvlFull) || pop_ok);
  assign dout_o   = mem_q[rd_ptr_q];
  assign level_o  = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (accept_o) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop_ok)   rd_ptr_d = rd_ptr_q + PtrOne;
    unique case ({accept_o, pop_ok})
      2'b10:   level_d = level_q + LvlOne;
      2'b01:   level_d = level_q - LvlOne;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept_o) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/axis_merge_2x.sv
// Merges two tready-less AXI streams through private FIFOs and a round-robin
// arbiter into one registered, source-tagged stream with sticky drop flags.
module axis_merge_2x
  import axis_merge_2x_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I1_tdata,
  input  logic             I1_tvalid,
  input  logic [WIDTH-1:0] I2_tdata,
  input  logic             I2_tvalid,
  output logic [WIDTH-1:0] O_tdata,
  output logic             O_tvalid,
  output logic             O_tid,
  input  logic             clr_ovf,
  output logic             ovf1,
  output logic             ovf2,
  output logic [AW:0]      lvl1,
  output logic [AW:0]      lvl2
);

  if (!depth_legal(DEPTH)) begin : g_depth_check
    $error("axis_merge_2x: DEPTH must be a power of two in 2..64");
  end

  logic [WIDTH-1:0] dout1, dout2;
  logic             accept1, accept2;
  logic             pop1, pop2;
  logic             gnt_valid, gnt_src;

  logic [WIDTH-1:0] o_tdata_q, o_tdata_d;
  logic             o_tvalid_q, o_tvalid_d;
  logic             o_tid_q, o_tid_d;
  logic             last_q, last_d;
  logic             ovf1_q, ovf1_d;
  logic             ovf2_q, ovf2_d;

  sync_fifo_nr #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (I1_tvalid),
    .pop_i   (pop1),
    .din_i   (I1_tdata),
    .dout_o  (dout1),
    .level_o (lvl1),
    .accept_o(accept1)
  );

  sync_fifo_nr #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo2 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (I2_tvalid),
    .pop_i   (pop2),
    .din_i   (I2_tdata),
    .dout_o  (dout2),
    .level_o (lvl2),
    .accept_o(accept2)
  );

  // Requests come from registered levels, so a fresh write waits one edge.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_src   = SRC_I1;
    if ((lvl1 != '0) && (lvl2 != '0)) begin
      gnt_valid = 1'b1;
      gnt_src   = (last_q == SRC_I2) ? SRC_I1 : SRC_I2;
    end else if (lvl1 != '0) begin
      gnt_valid = 1'b1;
      gnt_src   = SRC_I1;
    end else if (lvl2 != '0) begin
      gnt_valid = 1'b1;
      gnt_src   = SRC_I2;
    end
  end

  assign pop1 = gnt_valid && (gnt_src == SRC_I1);
  assign pop2 = gnt_valid && (gnt_src == SRC_I2);

  always_comb begin
    o_tvalid_d = gnt_valid;
    o_tdata_d  = o_tdata_q;
    o_tid_d    = o_tid_q;
    last_d     = last_q;
    if (gnt_valid) begin
      o_tdata_d = (gnt_src == SRC_I1) ? dout1 : dout2;
      o_tid_d   = gnt_src;
      last_d    = gnt_src;
    end
    // Set beats clear when a drop and clr_ovf share an edge.
    ovf1_d = (ovf1_q && !clr_ovf) || (I1_tvalid && !accept1);
    ovf2_d = (ovf2_q && !clr_ovf) || (I2_tvalid && !accept2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_tdata_q  <= '0;
      o_tvalid_q <= 1'b0;
      o_tid_q    <= SRC_I1;
      last_q     <= SRC_I2;
      ovf1_q     <= 1'b0;
      ovf2_q     <= 1'b0;
    end else begin
      o_tdata_q  <= o_tdata_d;
      o_tvalid_q <= o_tvalid_d;
      o_tid_q    <= o_tid_d;
      last_q     <= last_d;
      ovf1_q     <= ovf1_d;
      ovf2_q     <= ovf2_d;
    end
  end

  assign O_tdata  = o_tdata_q;
  assign O_tvalid = o_tvalid_q;
  assign O_tid    = o_tid_q;
  assign ovf1     = ovf1_q;
  assign ovf2     = ovf2_q;

endmodule

// File: tb/tb_axis_merge_2x.sv
// Directed bench for axis_merge_2x: a vector table for basic ordering plus
// hand-written saturation, overflow-clear, streaming and async-reset sequences.
module tb_axis_merge_2x;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] I1_tdata = '0, I2_tdata = '0;
  logic        I1_tvalid = 1'b0, I2_tvalid = 1'b0, clr_ovf = 1'b0;
  logic [15:0] O_tdata;
  logic        O_tvalid, O_tid, ovf1, ovf2;
  logic [3:0]  lvl1, lvl2;

  int checks = 0;
  int errors = 0;

  axis_merge_2x #(
    .WIDTH(16),
    .DEPTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .I1_tdata (I1_tdata),
    .I1_tvalid(I1_tvalid),
    .I2_tdata (I2_tdata),
    .I2_tvalid(I2_tvalid),
    .O_tdata  (O_tdata),
    .O_tvalid (O_tvalid),
    .O_tid    (O_tid),
    .clr_ovf  (clr_ovf),
    .ovf1     (ovf1),
    .ovf2     (ovf2),
    .lvl1     (lvl1),
    .lvl2     (lvl2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        v1;
    logic [15:0] d1;
    logic        v2;
    logic [15:0] d2;
    logic        clr;
    logic        ov;
    logic [15:0] od;
    logic        tid;
    logic [3:0]  l1;
    logic [3:0]  l2;
    logic        f1;
    logic        f2;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    I1_tvalid = 1'b0; I2_tvalid = 1'b0; clr_ovf = 1'b0;
    I1_tdata = '0; I2_tdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic v1, input logic [15:0] d1, input logic v2,
                       input logic [15:0] d2, input logic clr);
    I1_tvalid = v1; I1_tdata = d1; I2_tvalid = v2; I2_tdata = d2; clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        gap_ok, order_ok, rr_ok, tag_ok;
    logic [15:0] prev1, prev2;
    logic [3:0]  max1, max2;

    //         rst v1  d1       v2  d2       clr ov  od       tid l1 l2 f1 f2
    vecs[0]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 16'h0010, 1'b1, 16'h0020, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'h0011, 1'b1, 16'h0021, 1'b0, 1'b1, 16'h0010, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'h0012, 1'b1, 16'h0022, 1'b0, 1'b1, 16'h0020, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'h0013, 1'b1, 16'h0023, 1'b0, 1'b1, 16'h0011, 1'b0, 4'd2, 4'd3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0021, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0012, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0022, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0013, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0023, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0023, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0};

    // Reset values.
    do_reset();
    #1;
    chk("reset.tvalid", 32'(O_tvalid), 32'd0);
    chk("reset.tdata", 32'(O_tdata), 32'd0);
    chk("reset.tid", 32'(O_tid), 32'd0);
    chk("reset.lvl1", 32'(lvl1), 32'd0);
    chk("reset.lvl2", 32'(lvl2), 32'd0);
    chk("reset.ovf", 32'({ovf1, ovf2}), 32'd0);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst) do_reset();
      else @(negedge clk);
      drive(vecs[i].v1, vecs[i].d1, vecs[i].v2, vecs[i].d2, vecs[i].clr);
      chk($sformatf("vec%0d.tvalid", i), 32'(O_tvalid), 32'(vecs[i].ov));
      chk($sformatf("vec%0d.tdata", i), 32'(O_tdata), 32'(vecs[i].od));
      chk($sformatf("vec%0d.tid", i), 32'(O_tid), 32'(vecs[i].tid));
      chk($sformatf("vec%0d.lvl1", i), 32'(lvl1), 32'(vecs[i].l1));
      chk($sformatf("vec%0d.lvl2", i), 32'(lvl2), 32'(vecs[i].l2));
      chk($sformatf("vec%0d.ovf1", i), 32'(ovf1), 32'(vecs[i].f1));
      chk($sformatf("vec%0d.ovf2", i), 32'(ovf2), 32'(vecs[i].f2));
    end

    // Saturation: both inputs every cycle. Grants alternate, I1 on even edges.
    do_reset();
    gap_ok = 1'b1; order_ok = 1'b1; rr_ok = 1'b1; tag_ok = 1'b1;
    prev1 = '0; prev2 = '0; max1 = '0; max2 = '0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      drive(1'b1, 16'h0100 + 16'(n), 1'b1, 16'h0200 + 16'(n), 1'b0);
      if (lvl1 > max1) max1 = lvl1;
      if (lvl2 > max2) max2 = lvl2;
      if (n >= 2) begin
        if (!O_tvalid) gap_ok = 1'b0;
        if (O_tid !== ((n % 2 == 0) ? 1'b0 : 1'b1)) rr_ok = 1'b0;
        if (O_tid == 1'b0) begin
          if (O_tdata[15:8] != 8'h01) tag_ok = 1'b0;
          if (O_tdata <= prev1) order_ok = 1'b0;
          prev1 = O_tdata;
        end else begin
          if (O_tdata[15:8] != 8'h02) tag_ok = 1'b0;
          if (O_tdata <= prev2) order_ok = 1'b0;
          prev2 = O_tdata;
        end
      end
    end
    chk("sat.gapless", 32'(gap_ok), 32'd1);
    chk("sat.round_robin", 32'(rr_ok), 32'd1);
    chk("sat.tag", 32'(tag_ok), 32'd1);
    chk("sat.no_dup_in_order", 32'(order_ok), 32'd1);
    chk("sat.max_lvl1", 32'(max1), 32'd8);
    chk("sat.max_lvl2", 32'(max2), 32'd8);
    chk("sat.lvl1", 32'(lvl1), 32'd8);
    chk("sat.lvl2", 32'(lvl2), 32'd8);
    chk("sat.ovf1", 32'(ovf1), 32'd1);
    chk("sat.ovf2", 32'(ovf2), 32'd1);

    // Edge 41 grants I2, so the I1 beat drops while clr_ovf is high.
    @(negedge clk);
    drive(1'b1, 16'h01ff, 1'b0, 16'h0000, 1'b1);
    chk("clr_drop.ovf1", 32'(ovf1), 32'd1);
    chk("clr_drop.ovf2", 32'(ovf2), 32'd0);
    chk("clr_drop.tid", 32'(O_tid), 32'd1);
    chk("clr_drop.lvl1", 32'(lvl1), 32'd8);
    chk("clr_drop.lvl2", 32'(lvl2), 32'd7);
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    chk("clr_only.ovf1", 32'(ovf1), 32'd0);
    chk("clr_only.tid", 32'(O_tid), 32'd0);
    chk("clr_only.lvl1", 32'(lvl1), 32'd7);
    chk("clr_only.lvl2", 32'(lvl2), 32'd7);

    // I1 alone, every cycle: one-beat-deep pipeline, in order.
    do_reset();
    for (int n = 1; n <= 100; n++) begin
      if (n > 1) @(negedge clk);
      drive(1'b1, 16'h0300 + 16'(n), 1'b0, 16'h0000, 1'b0);
      chk($sformatf("i1only%0d.lvl1", n), 32'(lvl1), 32'd1);
      if (n == 1) begin
        chk("i1only1.tvalid", 32'(O_tvalid), 32'd0);
      end else begin
        chk($sformatf("i1only%0d.beat", n), 32'({O_tvalid, O_tid, O_tdata}),
            32'({1'b1, 1'b0, 16'h0300 + 16'(n - 1)}));
      end
    end
    chk("i1only.ovf1", 32'(ovf1), 32'd0);

    // Async reset mid-cycle with lvl1 at 5.
    do_reset();
    for (int n = 1; n <= 9; n++) begin
      if (n > 1) @(negedge clk);
      drive(1'b1, 16'h0400 + 16'(n), 1'b1, 16'h0500 + 16'(n), 1'b0);
    end
    chk("pre_rst.lvl1", 32'(lvl1), 32'd5);
    #2;
    rst_n = 1'b0;
    I1_tvalid = 1'b0; I2_tvalid = 1'b0;
    #1;
    chk("async_rst.outs", 32'({O_tvalid, O_tid, O_tdata, ovf1, ovf2}), 32'd0);
    chk("async_rst.lvl", 32'({lvl1, lvl2}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
      chk($sformatf("post_rst_idle%0d.tvalid", n), 32'(O_tvalid), 32'd0);
    end
    @(negedge clk);
    drive(1'b1, 16'h0abc, 1'b0, 16'h0000, 1'b0);
    chk("post_rst_first.tvalid", 32'(O_tvalid), 32'd0);
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    chk("post_rst_beat", 32'({O_tvalid, O_tid, O_tdata}), 32'({1'b1, 1'b0, 16'h0abc}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_merge_2x.md
Name: axis_merge_2x

Overview:
- Merges two tready-less AXI-stream producers (e.g. two demod branches, or two taps of a fanned-out stream) onto one tready-less consumer.
- Without back-pressure, each input gets a small private FIFO. A round-robin arbiter drains the FIFOs at up to one beat per clock.
- Each output beat carries a source tag. Lost samples are flagged with sticky overflow bits.
- It is the fan-in counterpart of the stream splitter, and sits between the symbol-rate datapath and a single shared consumer (DAC/UART/ILA path).

Parameters:
- WIDTH, 16, data width of all tdata buses.
- DEPTH, 8, per-input FIFO depth. Must be a power of two, 2..64.
- AW, $clog2(DEPTH), FIFO address width. Derived; do not override.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- I1_tdata  input  WIDTH  source 1 data.
- I1_tvalid  input  1  source 1 valid. A beat is offered on every clk edge where it is high.
- I2_tdata  input  WIDTH  source 2 data.
- I2_tvalid  input  1  source 2 valid.
- O_tdata  output  WIDTH  merged data, registered.
- O_tvalid  output  1  merged valid, registered. Consumer must accept every beat.
- O_tid  output  1  source of current beat: 0 = I1, 1 = I2.
- clr_ovf  input  1  synchronous clear of both overflow flags.
- ovf1  output  1  sticky: an I1 beat was dropped.
- ovf2  output  1  sticky: an I2 beat was dropped.
- lvl1  output  AW+1  FIFO1 occupancy, 0..DEPTH.
- lvl2  output  AW+1  FIFO2 occupancy.

Behaviour:
- Reset (async assert, sync-safe release):
  - O_tdata=0, O_tvalid=0, O_tid=0, ovf1=0, ovf2=0, lvl1=lvl2=0.
  - FIFO pointers = 0. Last-grant pointer = 1, so I1 wins the first contention.
  - Reset mid-operation discards all buffered beats; no partial beat is emitted.
- Write path, per input k:
  - push_k = Ik_tvalid. The beat is accepted if lvl_k < DEPTH, or if pop_k occurs in the same cycle.
  - Otherwise the beat is dropped, the FIFO is untouched, and ovf_k is set on that edge.
- Arbiter, combinational from registered occupancies:
  - req_k = (lvl_k != 0). A beat written on edge N is not visible to the arbiter until after edge N.
  - Exactly one req: grant it.
  - Both req: grant the source not granted last. The last-grant pointer updates only on an actual grant.
  - No req: no pop.
- Output register, each edge:
  - If any grant: O_tvalid=1, O_tdata=head of granted FIFO, O_tid=granted index; pop that FIFO.
  - Else: O_tvalid=0. O_tdata and O_tid hold their previous values.
- Latency and throughput:
  - Input beat at edge N into an empty FIFO, with no contention, appears on O after edge N+1 (2-edge latency).
  - Throughput is 1 beat/clk total. If both inputs sustain valid every cycle, each gets 1/2 and both FIFOs eventually overflow. This is legal and must be flagged.
- Occupancy:
  - lvl_k next = lvl_k + push_accepted − pop_k.
  - Simultaneous push and pop leaves lvl unchanged. This is allowed at lvl=DEPTH (no drop) and at lvl=0 only if lvl was non-zero, i.e. no bypass: an empty FIFO cannot be popped.
  - Pointers wrap modulo DEPTH.
- Overflow flags:
  - Set on drop, cleared by clr_ovf.
  - If clr_ovf and a drop land on the same edge, set wins (flag = 1).

Decomposition:
- Shared package/header: SRC_I1 = 1'b0, SRC_I2 = 1'b1 tag constants; DEPTH legality check macro.
- Sub-module sync_fifo_nr: single-clock FIFO with push, pop, din, dout (head, combinational read), level, and a full/accept output. Instantiated twice.
- Arbiter, output register and flags stay in the top module.

Test Plan:
- Reset, then a single I1 beat 0x1234 at edge 1 → O_tvalid=1, O_tdata=0x1234, O_tid=0 after edge 2 only; lvl1 returns to 0.
- I1 and I2 both valid for 4 cycles (I1: 0x10..0x13, I2: 0x20..0x23) → output order 0x10, 0x20, 0x11, 0x21, … with O_tid alternating 0,1; no ovf; O_tvalid continuous for 8 cycles.
- DEPTH=8: both inputs valid every cycle for 40 cycles → each FIFO reaches lvl=8; ovf1=ovf2=1; output stays gapless; each source is dropped and the merged stream has no duplicates.
- I1 only, valid every cycle for 100 cycles → lvl1 ≤ 1, no ovf, every beat emitted in order with O_tid=0.
- With ovf1=1, assert clr_ovf on the same edge as a new I1 drop → ovf1 stays 1. clr_ovf with no drop → ovf1=0.
- Assert rst_n low asynchronously (mid-clock) while lvl1=5 → all outputs 0 immediately; after release, the first output beat is a new input beat, never pre-reset data.
